// File: rtl/gelato_warp_split_table.sv
// Per-warp divergence table: holds live {pc, thread_mask} splits, round-robins a runnable
// split to issue, applies pipeline PC updates, splits on divergence and merges on reconvergence.
module gelato_warp_split_table #(
   parameter int  NUM_ENTRIES = 4,
   parameter int  ADDR_WIDTH  = 32,
   parameter int  THREAD_NUM  = 32,
   localparam int SN_W        = $clog2(NUM_ENTRIES)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  init_valid,
   input  logic [ADDR_WIDTH-1:0] init_pc,
   input  logic [THREAD_NUM-1:0] init_mask,
   output logic                  sel_valid,
   output logic [ADDR_WIDTH-1:0] sel_pc,
   output logic [SN_W-1:0]       sel_split_table_num,
   input  logic                  upd_valid,
   input  logic                  upd_stall,
   input  logic [ADDR_WIDTH-1:0] upd_pc,
   input  logic [SN_W-1:0]       upd_split_table_num,
   output logic [THREAD_NUM-1:0] upd_thread_mask,
   input  logic                  split_valid,
   input  logic [SN_W-1:0]       split_split_table_num,
   input  logic [THREAD_NUM-1:0] split_taken_mask,
   input  logic [ADDR_WIDTH-1:0] split_taken_pc,
   input  logic [ADDR_WIDTH-1:0] split_fall_pc,
   output logic                  split_ready,
   input  logic                  wb_valid,
   input  logic [SN_W-1:0]       wb_split_table_num,
   output logic                  warp_done,
   output logic                  overflow
);

   logic [NUM_ENTRIES-1:0] ent_vld;
   logic [NUM_ENTRIES-1:0] ent_stl;
   logic [ADDR_WIDTH-1:0]  ent_pc   [NUM_ENTRIES];
   logic [THREAD_NUM-1:0]  ent_mask [NUM_ENTRIES];

   logic [NUM_ENTRIES-1:0] nxt_vld;
   logic [NUM_ENTRIES-1:0] nxt_stl;
   logic [ADDR_WIDTH-1:0]  nxt_pc   [NUM_ENTRIES];
   logic [THREAD_NUM-1:0]  nxt_mask [NUM_ENTRIES];
   logic                   nxt_ovf;

   logic [NUM_ENTRIES-1:0] runnable;
   logic                   pick_vld;
   logic [SN_W-1:0]        pick_idx;
   logic                   free_found;
   logic [SN_W-1:0]        free_idx;

   logic [THREAD_NUM-1:0]  taken;
   logic                   split_hit;
   logic                   split_partial;
   logic                   split_alloc;
   logic                   split_ovf;
   logic                   upd_hit;
   logic [NUM_ENTRIES-1:0] touched;

   logic                   merge_found;
   logic [SN_W-1:0]        merge_lo;
   logic [SN_W-1:0]        merge_hi;

   assign runnable        = ent_vld & ~ent_stl;
   assign split_ready     = |(~ent_vld);
   assign warp_done       = ~|ent_vld;
   assign upd_thread_mask = ent_mask[upd_split_table_num];

   // Round-robin select: the registered index doubles as the rr pointer, scanned from rr+1
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = sel_split_table_num;
      for (int k = 1; k <= NUM_ENTRIES; k++) begin
         if (!pick_vld && runnable[sel_split_table_num + SN_W'(k)]) begin
            pick_vld = 1'b1;
            pick_idx = sel_split_table_num + SN_W'(k);
         end
      end
   end

   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         if (!free_found && !ent_vld[i]) begin
            free_found = 1'b1;
            free_idx   = SN_W'(i);
         end
      end
   end

   // Event decode; a split on the same entry swallows a concurrent update
   always_comb begin
      taken         = split_taken_mask & ent_mask[split_split_table_num];
      split_hit     = split_valid && ent_vld[split_split_table_num];
      split_partial = (taken != '0) && (taken != ent_mask[split_split_table_num]);
      split_alloc   = split_hit && split_partial && free_found;
      split_ovf     = split_hit && split_partial && !free_found;
      upd_hit       = upd_valid && ent_vld[upd_split_table_num] &&
                      !(split_hit && (upd_split_table_num == split_split_table_num));
      touched       = '0;
      if (split_hit)   touched[split_split_table_num] = 1'b1;
      if (split_alloc) touched[free_idx]              = 1'b1;
      if (upd_hit)     touched[upd_split_table_num]   = 1'b1;
   end

   always_comb begin
      merge_found = 1'b0;
      merge_lo    = '0;
      merge_hi    = '0;
      if (!init_valid) begin
         for (int i = 0; i < NUM_ENTRIES - 1; i++) begin
            for (int j = i + 1; j < NUM_ENTRIES; j++) begin
               if (!merge_found && runnable[i] && runnable[j] && !touched[i] && !touched[j] &&
                   (ent_pc[i] == ent_pc[j])) begin
                  merge_found = 1'b1;
                  merge_lo    = SN_W'(i);
                  merge_hi    = SN_W'(j);
               end
            end
         end
      end
   end

   // Writeback is applied before the update so a stalling update on the same entry wins
   always_comb begin
      nxt_vld  = ent_vld;
      nxt_stl  = ent_stl;
      nxt_pc   = ent_pc;
      nxt_mask = ent_mask;
      nxt_ovf  = overflow;
      if (init_valid) begin
         nxt_vld     = '0;
         nxt_stl     = '0;
         nxt_vld[0]  = 1'b1;
         nxt_pc[0]   = init_pc;
         nxt_mask[0] = init_mask;
         nxt_ovf     = 1'b0;
      end else begin
         if (wb_valid) nxt_stl[wb_split_table_num] = 1'b0;
         if (upd_hit) begin
            nxt_pc[upd_split_table_num]  = upd_pc;
            nxt_stl[upd_split_table_num] = upd_stall;
         end
         if (split_hit) begin
            if (taken == ent_mask[split_split_table_num] && taken != '0)
               nxt_pc[split_split_table_num] = split_taken_pc;
            else
               nxt_pc[split_split_table_num] = split_fall_pc;
         end
         if (split_alloc) begin
            nxt_mask[split_split_table_num] = ent_mask[split_split_table_num] & ~taken;
            nxt_vld[free_idx]  = 1'b1;
            nxt_stl[free_idx]  = 1'b0;
            nxt_pc[free_idx]   = split_taken_pc;
            nxt_mask[free_idx] = taken;
         end
         if (split_ovf) nxt_ovf = 1'b1;
         if (merge_found) begin
            nxt_mask[merge_lo] = ent_mask[merge_lo] | ent_mask[merge_hi];
            nxt_vld[merge_hi]  = 1'b0;
         end
      end
   end

   // Registered state boundary: control and select outputs reset, entry payload does not
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ent_vld             <= '0;
         ent_stl             <= '0;
         overflow            <= 1'b0;
         sel_valid           <= 1'b0;
         sel_pc              <= '0;
         sel_split_table_num <= '0;
      end else begin
         ent_vld   <= nxt_vld;
         ent_stl   <= nxt_stl;
         overflow  <= nxt_ovf;
         sel_valid <= pick_vld;
         if (pick_vld) begin
            sel_pc              <= ent_pc[pick_idx];
            sel_split_table_num <= pick_idx;
         end
      end
   end

   always_ff @(posedge clk) begin
      ent_pc   <= nxt_pc;
      ent_mask <= nxt_mask;
   end

endmodule

// File: tb/tb_gelato_warp_split_table.sv
// Bench for gelato_warp_split_table: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a table-level reference model.
module tb_gelato_warp_split_table;

   localparam int N = 4;

   typedef struct packed {
      logic        v;
      logic        s;
      logic [31:0] pc;
      logic [31:0] m;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        init_valid = 1'b0;
   logic [31:0] init_pc = '0;
   logic [31:0] init_mask = '0;
   logic        sel_valid;
   logic [31:0] sel_pc;
   logic [1:0]  sel_split_table_num;
   logic        upd_valid = 1'b0;
   logic        upd_stall = 1'b0;
   logic [31:0] upd_pc = '0;
   logic [1:0]  upd_split_table_num = '0;
   logic [31:0] upd_thread_mask;
   logic        split_valid = 1'b0;
   logic [1:0]  split_split_table_num = '0;
   logic [31:0] split_taken_mask = '0;
   logic [31:0] split_taken_pc = '0;
   logic [31:0] split_fall_pc = '0;
   logic        split_ready;
   logic        wb_valid = 1'b0;
   logic [1:0]  wb_split_table_num = '0;
   logic        warp_done;
   logic        overflow;

   int   n_chk = 0;
   int   n_fail = 0;
   bit   chk_en = 1'b0;

   ent_t        tbl [N];
   logic        m_ovf;
   logic        m_sel_vld;
   logic [31:0] m_sel_pc;
   int          m_rr;
   logic [31:0] pool [4];

   gelato_warp_split_table dut (
      .clk(clk), .rst_n(rst_n),
      .init_valid(init_valid), .init_pc(init_pc), .init_mask(init_mask),
      .sel_valid(sel_valid), .sel_pc(sel_pc), .sel_split_table_num(sel_split_table_num),
      .upd_valid(upd_valid), .upd_stall(upd_stall), .upd_pc(upd_pc),
      .upd_split_table_num(upd_split_table_num), .upd_thread_mask(upd_thread_mask),
      .split_valid(split_valid), .split_split_table_num(split_split_table_num),
      .split_taken_mask(split_taken_mask), .split_taken_pc(split_taken_pc),
      .split_fall_pc(split_fall_pc), .split_ready(split_ready),
      .wb_valid(wb_valid), .wb_split_table_num(wb_split_table_num),
      .warp_done(warp_done), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic m_reset();
      for (int i = 0; i < N; i++) tbl[i] = '0;
      m_ovf     = 1'b0;
      m_sel_vld = 1'b0;
      m_sel_pc  = '0;
      m_rr      = 0;
   endtask

   // Reference: apply the table rules to the pre-edge state, produce the post-edge state
   task automatic m_step();
      ent_t        nt [N];
      bit          wr [N];
      int          pick, s, u, w, f;
      logic [31:0] t;
      bit          sp, up, merged;
      pick = -1;
      for (int k = 1; k <= N; k++)
         if (pick < 0 && tbl[(m_rr + k) % N].v && !tbl[(m_rr + k) % N].s) pick = (m_rr + k) % N;
      if (pick >= 0) begin
         m_sel_vld = 1'b1;
         m_sel_pc  = tbl[pick].pc;
         m_rr      = pick;
      end else begin
         m_sel_vld = 1'b0;
      end
      nt = tbl;
      for (int i = 0; i < N; i++) wr[i] = 1'b0;
      if (init_valid) begin
         for (int i = 0; i < N; i++) begin
            nt[i].v = 1'b0;
            nt[i].s = 1'b0;
         end
         nt[0] = '{v: 1'b1, s: 1'b0, pc: init_pc, m: init_mask};
         m_ovf = 1'b0;
      end else begin
         s  = int'(split_split_table_num);
         u  = int'(upd_split_table_num);
         w  = int'(wb_split_table_num);
         sp = split_valid && tbl[s].v;
         up = upd_valid && tbl[u].v && !(sp && u == s);
         if (wb_valid) nt[w].s = 1'b0;
         if (up) begin
            nt[u].pc = upd_pc;
            nt[u].s  = upd_stall;
            wr[u]    = 1'b1;
         end
         if (sp) begin
            t     = split_taken_mask & tbl[s].m;
            wr[s] = 1'b1;
            if (t == 0) nt[s].pc = split_fall_pc;
            else if (t == tbl[s].m) nt[s].pc = split_taken_pc;
            else begin
               f = -1;
               for (int i = 0; i < N; i++) if (f < 0 && !tbl[i].v) f = i;
               nt[s].pc = split_fall_pc;
               if (f < 0) m_ovf = 1'b1;
               else begin
                  nt[s].m = tbl[s].m & ~t;
                  nt[f]   = '{v: 1'b1, s: 1'b0, pc: split_taken_pc, m: t};
                  wr[f]   = 1'b1;
               end
            end
         end
         merged = 1'b0;
         for (int i = 0; i < N - 1; i++)
            for (int j = i + 1; j < N; j++)
               if (!merged && tbl[i].v && !tbl[i].s && tbl[j].v && !tbl[j].s &&
                   !wr[i] && !wr[j] && tbl[i].pc == tbl[j].pc) begin
                  merged   = 1'b1;
                  nt[i].m  = tbl[i].m | tbl[j].m;
                  nt[j].v  = 1'b0;
               end
      end
      tbl = nt;
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m_reset();
      else m_step();
   end

   always @(negedge clk) begin : compare
      bit any_free, any_vld;
      if (chk_en) begin
         any_free = 1'b0;
         any_vld  = 1'b0;
         for (int i = 0; i < N; i++) begin
            if (tbl[i].v) any_vld = 1'b1;
            else any_free = 1'b1;
         end
         chk("sel_valid", 32'(sel_valid), 32'(m_sel_vld));
         chk("sel_pc", sel_pc, m_sel_pc);
         chk("sel_num", 32'(sel_split_table_num), 32'(m_rr));
         chk("split_ready", 32'(split_ready), 32'(any_free));
         chk("warp_done", 32'(warp_done), 32'(!any_vld));
         chk("overflow", 32'(overflow), 32'(m_ovf));
         if (tbl[upd_split_table_num].v)
            chk("upd_thread_mask", upd_thread_mask, tbl[upd_split_table_num].m);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      init_valid  = 1'b0;
      upd_valid   = 1'b0;
      upd_stall   = 1'b0;
      split_valid = 1'b0;
      wb_valid    = 1'b0;
   endtask

   task automatic do_init(input logic [31:0] pc, input logic [31:0] mask);
      init_valid = 1'b1; init_pc = pc; init_mask = mask;
      tick(); idle();
   endtask

   task automatic do_split(input logic [1:0] n, input logic [31:0] tm,
                           input logic [31:0] tpc, input logic [31:0] fpc);
      split_valid = 1'b1; split_split_table_num = n; split_taken_mask = tm;
      split_taken_pc = tpc; split_fall_pc = fpc;
      tick(); idle();
   endtask

   task automatic do_upd(input logic [1:0] n, input logic [31:0] pc, input logic st);
      upd_valid = 1'b1; upd_split_table_num = n; upd_pc = pc; upd_stall = st;
      tick(); idle();
   endtask

   initial begin
      pool[0] = 32'h100; pool[1] = 32'h104; pool[2] = 32'h108; pool[3] = 32'h10C;
      m_reset();
      tick(); tick();
      chk_en = 1'b1;
      chk("rst_sel_valid", 32'(sel_valid), 32'd0);
      chk("rst_sel_pc", sel_pc, 32'd0);
      chk("rst_warp_done", 32'(warp_done), 32'd1);
      chk("rst_split_ready", 32'(split_ready), 32'd1);
      chk("rst_overflow", 32'(overflow), 32'd0);
      rst_n = 1'b1;

      do_init(32'h100, 32'hFFFF_FFFF);
      chk("init_warp_done", 32'(warp_done), 32'd0);
      tick();
      chk("init_sel_valid", 32'(sel_valid), 32'd1);
      chk("init_sel_pc", sel_pc, 32'h100);
      chk("init_sel_num", 32'(sel_split_table_num), 32'd0);

      do_split(2'd0, 32'h0000_FFFF, 32'h200, 32'h104);
      upd_split_table_num = 2'd1; #1;
      chk("split_mask1", upd_thread_mask, 32'h0000_FFFF);
      upd_split_table_num = 2'd0; #1;
      chk("split_mask0", upd_thread_mask, 32'hFFFF_0000);
      tick();
      chk("alt_num_a", 32'(sel_split_table_num), 32'd1);
      chk("alt_pc_a", sel_pc, 32'h200);
      tick();
      chk("alt_num_b", 32'(sel_split_table_num), 32'd0);
      chk("alt_pc_b", sel_pc, 32'h104);

      do_upd(2'd1, 32'h300, 1'b0);
      do_upd(2'd0, 32'h300, 1'b0);
      tick();
      upd_split_table_num = 2'd0; #1;
      chk("merge_mask", upd_thread_mask, 32'hFFFF_FFFF);
      chk("merge_ready", 32'(split_ready), 32'd1);
      tick(); tick();
      chk("merge_sel_num", 32'(sel_split_table_num), 32'd0);
      chk("merge_sel_pc", sel_pc, 32'h300);

      do_upd(2'd0, 32'h304, 1'b1);
      tick();
      chk("stall_sel_valid", 32'(sel_valid), 32'd0);
      wb_valid = 1'b1; wb_split_table_num = 2'd0;
      tick(); idle(); tick();
      chk("wb_sel_valid", 32'(sel_valid), 32'd1);
      chk("wb_sel_pc", sel_pc, 32'h304);
      wb_valid = 1'b1; wb_split_table_num = 2'd0;
      do_upd(2'd0, 32'h308, 1'b1);
      tick(); tick();
      chk("wb_upd_stalled", 32'(sel_valid), 32'd0);
      wb_valid = 1'b1;
      tick(); idle(); tick();

      do_init(32'h100, 32'hFFFF_FFFF);
      do_split(2'd0, 32'h0000_FFFF, 32'h200, 32'h104);
      do_split(2'd0, 32'h00FF_0000, 32'h210, 32'h108);
      do_split(2'd1, 32'h0000_00FF, 32'h220, 32'h204);
      chk("full_ready", 32'(split_ready), 32'd0);
      do_split(2'd0, 32'h0F00_0000, 32'h230, 32'h10C);
      upd_split_table_num = 2'd0; #1;
      chk("ovf_set", 32'(overflow), 32'd1);
      chk("ovf_ready", 32'(split_ready), 32'd0);
      chk("ovf_src_mask", upd_thread_mask, 32'hFF00_0000);
      do_init(32'h100, 32'hFFFF_FFFF);
      chk("ovf_cleared", 32'(overflow), 32'd0);

      do_split(2'd0, 32'h0, 32'h150, 32'h140);
      tick(); tick();
      chk("deg0_pc", sel_pc, 32'h140);
      chk("deg0_mask", upd_thread_mask, 32'hFFFF_FFFF);
      do_split(2'd0, 32'hFFFF_FFFF, 32'h160, 32'h144);
      tick(); tick();
      chk("degF_pc", sel_pc, 32'h160);
      tick();
      chk("degF_num", 32'(sel_split_table_num), 32'd0);

      for (int c = 0; c < 3000; c++) begin
         if (c == 1500) begin
            rst_n = 1'b0; #1;
            chk("midrst_sel_valid", 32'(sel_valid), 32'd0);
            chk("midrst_warp_done", 32'(warp_done), 32'd1);
            chk("midrst_overflow", 32'(overflow), 32'd0);
            tick();
            rst_n = 1'b1;
         end
         init_valid = (tbl[0].v == 1'b0 && tbl[1].v == 1'b0 && tbl[2].v == 1'b0 &&
                       tbl[3].v == 1'b0) || ($urandom_range(0, 99) < 2);
         init_pc    = pool[$urandom_range(0, 3)];
         init_mask  = $urandom | 32'h1;
         upd_valid  = $urandom_range(0, 99) < 40;
         upd_stall  = $urandom_range(0, 99) < 30;
         upd_pc     = pool[$urandom_range(0, 3)];
         upd_split_table_num = 2'($urandom_range(0, 3));
         split_valid = $urandom_range(0, 99) < 30;
         split_split_table_num = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 3))
            0: split_taken_mask = '0;
            1: split_taken_mask = '1;
            default: split_taken_mask = $urandom;
         endcase
         split_taken_pc = pool[$urandom_range(0, 3)];
         split_fall_pc  = pool[$urandom_range(0, 3)];
         wb_valid = $urandom_range(0, 99) < 35;
         wb_split_table_num = 2'($urandom_range(0, 3));
         tick();
      end
      idle();
      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/gelato_warp_split_table.md
Name: gelato_warp_split_table

Overview:
Per-warp divergence table. It is the slave end of the split-table update path and the master end of the split-table select path.
It holds up to NUM_ENTRIES live splits of a warp, each a {pc, thread_mask} pair. It round-robins a runnable split out to the issue stage and applies PC updates from the pipeline. It also splits entries on divergent branches and merges entries that reconverge on the same PC.

Parameters:
NUM_ENTRIES, 4, number of split entries (power of two, >=2); SN_W = log2(NUM_ENTRIES)
ADDR_WIDTH, 32, PC width
THREAD_NUM, 32, threads per warp (thread_mask width)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
init_valid  in  1  load a new warp into entry 0
init_pc  in  ADDR_WIDTH  start PC
init_mask  in  THREAD_NUM  start thread mask
sel_valid  out  1  registered: a runnable split is presented
sel_pc  out  ADDR_WIDTH  registered PC of the selected split
sel_split_table_num  out  SN_W  registered index of the selected split
upd_valid  in  1  PC update for one entry
upd_stall  in  1  with upd_valid: the entry waits for writeback after the update
upd_pc  in  ADDR_WIDTH  new PC
upd_split_table_num  in  SN_W  entry being updated
upd_thread_mask  out  THREAD_NUM  combinational mask of entry[upd_split_table_num]
split_valid  in  1  divergent branch on one entry
split_split_table_num  in  SN_W  entry that branched
split_taken_mask  in  THREAD_NUM  threads taking the branch
split_taken_pc  in  ADDR_WIDTH  branch target
split_fall_pc  in  ADDR_WIDTH  fall-through PC
split_ready  out  1  at least one free entry
wb_valid  in  1  writeback releases a stall
wb_split_table_num  in  SN_W  entry released
warp_done  out  1  no valid entries
overflow  out  1  sticky: a split needing allocation arrived with no free entry

Behaviour:
- Entry state: valid, stalled, pc, mask.
- Reset values: all entries invalid and unstalled; sel_valid=0, sel_pc=0, sel_split_table_num=0; rr pointer=0; overflow=0; warp_done=1.
- Reset is asynchronous and may assert mid-operation; all state clears immediately.
- init_valid:
  - entry0 becomes {valid, !stalled, init_pc, init_mask}; all other entries are invalidated.
  - Overflow is cleared.
  - Overrides every other event in that cycle.
- Runnable entry: valid && !stalled.
- Select (1-cycle latency):
  - Each cycle, scan from rr+1 upward with wrap-around, using the current registered state.
  - Pick the first runnable entry, register its pc and index, set sel_valid=1, and set rr to that index.
  - No runnable entry -> sel_valid=0; pc and index hold.
- Update, applied when upd_valid and the target entry is valid:
  - entry.pc <= upd_pc.
  - entry.stalled <= upd_stall.
  - An update to an invalid entry is ignored.
- Split, applied when split_valid on a valid entry e; define t = split_taken_mask & e.mask:
  - t == 0: e.pc <= split_fall_pc.
  - t == e.mask: e.pc <= split_taken_pc.
  - Otherwise:
    - e.mask <= e.mask & ~t, e.pc <= split_fall_pc.
    - Allocate the lowest-index free entry f: {valid, !stalled, split_taken_pc, t}.
    - If no entry is free, only e is updated, with pc <= split_fall_pc and mask unchanged; overflow is set.
  - Split and update to the same entry in one cycle: split wins and the update is dropped.
- Writeback: wb_valid clears stalled on the target entry.
  - Same entry also updated with upd_stall=1 in that cycle: update wins and the entry stays stalled.
- Merge, at most one per cycle:
  - Candidate pair: lowest pair i<j, both runnable, equal pc, and neither written by init, split, update or allocation this cycle.
  - Action: entry[i].mask <= mask_i | mask_j; entry[j] is invalidated.
- Free entry: !valid. split_ready = any free entry. warp_done = no valid entries. Both are combinational from registered state.
- An entry with mask==0 is never created.

Test Plan:
- Reset, then init_pc=0x100, init_mask=0xFFFFFFFF -> next cycle sel_valid=1, sel_pc=0x100, num=0; warp_done=0.
- Split on entry0 with taken_mask=0x0000FFFF, taken_pc=0x200, fall_pc=0x104:
  - entry0 becomes {0x104, 0xFFFF0000}; entry1 becomes {0x200, 0x0000FFFF}.
  - sel alternates 1,0,1,...
  - upd_thread_mask for num=1 reads 0x0000FFFF.
- Reconverge: update entry1 pc to 0x300, then entry0 pc to 0x300 -> following cycle entry0 mask=0xFFFFFFFF, entry1 invalid, split_ready=1.
- Stall and writeback: upd_valid, upd_stall=1 on the only entry -> sel_valid=0 from the next cycle. wb_valid on that entry -> sel_valid=1 again. Simultaneous wb and stalled update -> remains stalled.
- Full table: fill all 4 entries via splits, then split again with a partial mask -> split_ready=0, overflow=1, source pc=fall_pc, source mask unchanged. init_valid then clears overflow.
- Degenerate masks: split with taken_mask=0 -> only pc=fall_pc. taken_mask covering the whole entry mask -> only pc=taken_pc. No allocation in either case.
